aes128_round_unit: RTL and testbench

- Parametrised, multi-mode successor to the single-round AES-128 datapath; executes exactly one round per accepted start.
- Three modes: full round (SubBytes, ShiftRows, MixColumns, AddRoundKey), final round (no MixColumns) and whitening (AddRoundKey only).
- SubBytes is time-multiplexed over SBOX_LANES S-box instances, trading latency for area.
- Sits under the iterative AES-128 encrypt controller, which sequences modes and round keys.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_sbox_lanes.sv | 17 +
 rtl/aes128_round_unit.sv | 176 +++++++++++++++++
 tb/tb_aes128_round_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the round unit and its bench.
// Holds the byte type, round-unit FSM state type, mode encodings, GF(2^8)
// helpers (xtime, mul2, mul3) and the FIPS-197 forward S-box.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {StIdle, StSub, StMix} round_state_e;

  localparam logic [1:0] MODE_FULL   = 2'd0;
  localparam logic [1:0] MODE_FINAL  = 2'd1;
  localparam logic [1:0] MODE_WHITEN = 2'd2;

  // Entry for input byte b sits at bits [2047-8b -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t mul2(input aes_byte_t b);
    return xtime(b);
  endfunction

  function automatic aes_byte_t mul3(input aes_byte_t b);
    return xtime(b) ^ b;
  endfunction

  function automatic aes_byte_t sbox(input aes_byte_t b);
    return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox_lanes.sv
// LANES parallel forward S-box lookups, purely combinational.
// Ports:
//   din   LANES*8-bit bus of input bytes
//   dout  LANES*8-bit bus of substituted bytes, lane k maps din[8k+:8] -> dout[8k+:8]
module aes_sbox_lanes #(
  parameter int unsigned LANES = 4
) (
  input  logic [LANES*8-1:0] din,
  output logic [LANES*8-1:0] dout
);
  import aes_pkg::*;

  for (genvar k = 0; k < LANES; k++) begin : gen_lane
    assign dout[8*k +: 8] = sbox(din[8*k +: 8]);
  end

endmodule

// File: rtl/aes128_round_unit.sv
// One AES-128 round per accepted start: full round, final round (no MixColumns)
// or whitening (AddRoundKey only). SubBytes is spread over SUB_BEATS cycles
// using SBOX_LANES S-boxes.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      round request, accepted only while busy=0
//   mode       0 full, 1 final, 2 whitening, 3 treated as full
//   state_in   input state, byte i = bits [127-8i -: 8]
//   round_key  round key
//   state_out  registered round result, held until the next accepted start
//   busy       round in progress
//   done       high from completion until the next accepted start
module aes128_round_unit #(
  parameter int unsigned SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out,
  output logic         busy,
  output logic         done
);
  import aes_pkg::*;

  localparam int unsigned SUB_BEATS = 16 / SBOX_LANES;
  localparam int unsigned SliceW    = 8 * SBOX_LANES;
  localparam int unsigned BeatW     = (SUB_BEATS > 1) ? $clog2(SUB_BEATS) : 1;

  if ((SBOX_LANES != 1) && (SBOX_LANES != 2) && (SBOX_LANES != 4) &&
      (SBOX_LANES != 8) && (SBOX_LANES != 16)) begin : gen_bad_lanes
    $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  round_state_e     fsm_q, fsm_d;
  logic [127:0]     work_q, work_d;
  logic [127:0]     key_q, key_d;
  logic [1:0]       mode_q, mode_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [127:0]     out_q, out_d;
  logic             done_q, done_d;
  // Whitening result is written one edge after acceptance without leaving IDLE.
  logic             whiten_q, whiten_d;

  logic [SliceW-1:0] sub_in, sub_out;
  logic [127:0]      mix_res;
  int unsigned       beat_idx;

  assign beat_idx = 32'(beat_q);
  assign sub_in   = work_q[127 - SliceW * beat_idx -: SliceW];

  aes_sbox_lanes #(
    .LANES(SBOX_LANES)
  ) u_sbox_lanes (
    .din (sub_in),
    .dout(sub_out)
  );

  // ShiftRows, optional MixColumns and AddRoundKey on the fully substituted state.
  always_comb begin
    aes_byte_t sr [16];
    aes_byte_t mc [16];
    aes_byte_t a0, a1, a2, a3;
    mix_res = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int i = 0; i < 16; i++) begin
      sr[i] = '0;
      mc[i] = '0;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[4*r+c] = work_q[127 - 8 * (4*r + ((c + r) % 4)) -: 8];
      end
    end
    for (int j = 0; j < 4; j++) begin
      a0 = sr[j];
      a1 = sr[j+4];
      a2 = sr[j+8];
      a3 = sr[j+12];
      if (mode_q == MODE_FINAL) begin
        mc[j]    = a0;
        mc[j+4]  = a1;
        mc[j+8]  = a2;
        mc[j+12] = a3;
      end else begin
        mc[j]    = mul2(a0) ^ mul3(a1) ^ a2 ^ a3;
        mc[j+4]  = a0 ^ mul2(a1) ^ mul3(a2) ^ a3;
        mc[j+8]  = a0 ^ a1 ^ mul2(a2) ^ mul3(a3);
        mc[j+12] = mul3(a0) ^ a1 ^ a2 ^ mul2(a3);
      end
    end
    for (int i = 0; i < 16; i++) begin
      mix_res[127 - 8*i -: 8] = mc[i] ^ key_q[127 - 8*i -: 8];
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    work_d   = work_q;
    key_d    = key_q;
    mode_d   = mode_q;
    beat_d   = beat_q;
    out_d    = out_q;
    done_d   = done_q;
    whiten_d = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (whiten_q) begin
          out_d  = work_q ^ key_q;
          done_d = 1'b1;
        end
        // A new start wins over a completing whitening for the done flag.
        if (start) begin
          work_d = state_in;
          key_d  = round_key;
          mode_d = mode;
          beat_d = '0;
          done_d = 1'b0;
          if (mode == MODE_WHITEN) begin
            whiten_d = 1'b1;
          end else begin
            fsm_d = StSub;
          end
        end
      end
      StSub: begin
        work_d[127 - SliceW * beat_idx -: SliceW] = sub_out;
        if (beat_q == BeatW'(SUB_BEATS - 1)) begin
          beat_d = '0;
          fsm_d  = StMix;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StMix: begin
        out_d  = mix_res;
        done_d = 1'b1;
        fsm_d  = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q    <= StIdle;
      work_q   <= '0;
      key_q    <= '0;
      mode_q   <= MODE_FULL;
      beat_q   <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      whiten_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      work_q   <= work_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      beat_q   <= beat_d;
      out_q    <= out_d;
      done_q   <= done_d;
      whiten_q <= whiten_d;
    end
  end

  assign state_out = out_q;
  assign done      = done_q;
  assign busy      = (fsm_q != StIdle);

endmodule

// File: tb/tb_aes128_round_unit.sv
// Bench for aes128_round_unit: five instances (SBOX_LANES 1..16) share all
// inputs; each result and completion latency is compared to a byte-matrix
// reference model of the round.
module tb_aes128_round_unit;
  import aes_pkg::*;

  localparam int NDUT = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic [127:0] state_out [NDUT];
  logic         busy [NDUT];
  logic         done [NDUT];

  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] last_exp;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    aes128_round_unit #(
      .SBOX_LANES(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .state_in (state_in),
      .round_key(round_key),
      .state_out(state_out[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // State held as a 4x4 row-major byte matrix; MixColumns as a circulant product.
  function automatic logic [127:0] round_model(input logic [1:0] m, input logic [127:0] s,
                                               input logic [127:0] k);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   o [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    if (m == MODE_WHITEN) return s ^ k;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127 - 8*i -: 8]);
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) t[4*row + col] = b[4*row + (col + row) % 4];
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) a[i] = t[j + 4*i];
      for (int i = 0; i < 4; i++) begin
        if (m == MODE_FINAL) o[j + 4*i] = a[i];
        else o[j + 4*i] = gmul(a[i], 8'd2) ^ gmul(a[(i+1)%4], 8'd3) ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = o[i];
    return res ^ k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_round(input string tag, input logic [1:0] m, input logic [127:0] s,
                           input logic [127:0] k, input bit pulse_busy);
    logic [127:0] exp;
    int           seen [NDUT];
    bit           busy_hi;
    bit           all_seen;
    int           lat_exp;
    exp = round_model(m, s, k);
    last_exp = exp;
    busy_hi = 1'b0;
    for (int g = 0; g < NDUT; g++) seen[g] = 0;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    state_in = s;
    round_key = k;
    @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check_eq($sformatf("%s done_clear L%0d", tag, 1 << g), 128'(done[g]), 128'd0);
      if (busy[g]) busy_hi = 1'b1;
    end
    // Inputs may change freely once the round is accepted.
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom);
    state_in = rand128();
    round_key = rand128();
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      all_seen = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if (seen[g] == 0 && done[g]) seen[g] = n;
        if (seen[g] == 0) all_seen = 1'b0;
        if (busy[g]) busy_hi = 1'b1;
      end
      if (all_seen) break;
      @(negedge clk);
      // At this point every instance is still mid-round, so this start must be ignored.
      start = (pulse_busy && n == 1);
      mode = MODE_FULL;
    end
    start = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      lat_exp = (m == MODE_WHITEN) ? 1 : 16 / (1 << g) + 1;
      check_eq($sformatf("%s latency L%0d", tag, 1 << g), 128'(seen[g]), 128'(lat_exp));
      check_eq($sformatf("%s result L%0d", tag, 1 << g), state_out[g], exp);
    end
    if (m == MODE_WHITEN) check_eq({tag, " busy_never_high"}, 128'(busy_hi), 128'd0);
  endtask

  initial begin
    logic [1:0] rm;
    rst = 1'b0;
    start = 1'b0;
    mode = MODE_FULL;
    state_in = '0;
    round_key = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check_eq($sformatf("reset out L%0d", 1 << g), state_out[g], 128'd0);
      check_eq($sformatf("reset busy L%0d", 1 << g), 128'(busy[g]), 128'd0);
      check_eq($sformatf("reset done L%0d", 1 << g), 128'(done[g]), 128'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    run_round("whiten", MODE_WHITEN, 128'h00112233445566778899aabbccddeeff,
              128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
    check_eq("whiten vector", last_exp, 128'h0f1f2f3f4f5f6f7f8f9fafbfcfdfefff);
    run_round("final", MODE_FINAL, 128'h000102030405060708090a0b0c0d0e0f, 128'd0, 1'b0);
    check_eq("final vector", last_exp, 128'h637c777b6b6fc5f2672b300176fed7ab);
    run_round("keyadd", MODE_FULL, 128'd0, {128{1'b1}}, 1'b1);
    check_eq("keyadd vector", last_exp, {16{8'h9c}});
    // Back-to-back: each start lands in the cycle the previous done rose.
    run_round("b2b_full", MODE_FULL, rand128(), rand128(), 1'b0);
    run_round("b2b_whiten", MODE_WHITEN, rand128(), rand128(), 1'b0);
    run_round("b2b_final", MODE_FINAL, rand128(), rand128(), 1'b0);

    for (int v = 0; v < 50; v++) begin
      rm = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 1));
      run_round($sformatf("rand%0d", v), rm, rand128(), rand128(), 1'($urandom_range(0, 1)));
    end

    // Result and done hold while idle.
    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check_eq($sformatf("hold out L%0d", 1 << g), state_out[g], last_exp);
      check_eq($sformatf("hold done L%0d", 1 << g), 128'(done[g]), 128'd1);
    end

    // Reset in the middle of SubBytes aborts the round.
    @(negedge clk);
    start = 1'b1;
    mode = MODE_FULL;
    state_in = rand128();
    round_key = rand128();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check_eq($sformatf("abort out L%0d", 1 << g), state_out[g], 128'd0);
      check_eq($sformatf("abort busy L%0d", 1 << g), 128'(busy[g]), 128'd0);
      check_eq($sformatf("abort done L%0d", 1 << g), 128'(done[g]), 128'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++)
      check_eq($sformatf("abort no_done L%0d", 1 << g), 128'(done[g]), 128'd0);
    run_round("post_reset", MODE_FULL, 128'd0, 128'd0, 1'b0);
    check_eq("post_reset vector", last_exp, {16{8'h63}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
